// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: occupancy encoding, debug view and default widths
// for the skid-buffered pipeline stage.
package pipe_stage_skid_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   typedef struct packed {
      occ_e state;
      logic stall;
   } dbg_t;

   // Number of valid entries held in a given occupancy state.
   function automatic logic [1:0] occ_count(input occ_e s);
      case (s)
         OCC_ONE:  occ_count = 2'd1;
         OCC_FULL: occ_count = 2'd2;
         default:  occ_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and control bundle of one pipeline boundary, named from the stage's side.
interface pipe_stage_skid_if
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   // Valid/ready: a beat moves on a rising edge where valid && ready; the output
   // side additionally requires !stall_i. Valid and data hold until the beat moves.
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic              stall_i;
   logic              flush_i;

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
      output in_ready_o, out_valid_o, out_data_o
   );

   modport master (
      output in_valid_i, in_data_i, out_ready_i, stall_i, flush_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Counter that adds 0..2 per cycle and sticks at its all-ones maximum.
module sat_counter
   import pipe_stage_skid_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [1:0]       inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;

   // One extra bit of headroom so the overflow is visible before clamping.
   always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_W + 1)'(inc_i);
      cnt_d = (sum > MAX) ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with registered ready, hazard stall, flush and a
// saturating count of entries discarded by flush.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   pipe_stage_skid_if.slave bus,
   output logic [CNT_W-1:0] drop_cnt_o,
   output dbg_t             dbg_o
);

   occ_e              state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              stall_q;
   logic              accept, rel;
   logic [1:0]        drop_inc;

   always_comb begin
      accept   = bus.in_valid_i && in_ready_q;
      rel      = (state_q != OCC_EMPTY) && bus.out_ready_i && !bus.stall_i;
      state_d  = state_q;
      head_d   = head_q;
      skid_d   = skid_q;
      drop_inc = 2'd0;
      if (bus.flush_i) begin
         // Flush wins over everything, including a beat accepted this same edge.
         state_d  = OCC_EMPTY;
         drop_inc = occ_count(state_q);
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  state_d = OCC_ONE;
                  head_d  = bus.in_data_i;
               end
            end
            OCC_ONE: begin
               if (accept && rel) begin
                  head_d = bus.in_data_i;
               end else if (accept) begin
                  state_d = OCC_FULL;
                  skid_d  = bus.in_data_i;
               end else if (rel) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (rel) begin
                  state_d = OCC_ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
      // Registered so ready never depends combinationally on out_ready_i or stall_i.
      in_ready_d = (state_d != OCC_FULL) && !bus.stall_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= OCC_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
         stall_q    <= bus.stall_i;
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = (state_q != OCC_EMPTY);
   assign bus.out_data_o  = (state_q != OCC_EMPTY) ? head_q : BUBBLE_VAL;
   assign dbg_o.state     = state_q;
   assign dbg_o.stall     = stall_q;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_drop_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (drop_inc),
      .cnt_o   (drop_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue-based reference model, and a narrow-counter saturation instance.
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_stage_skid_if #(.DATA_W(64)) b1 ();
   pipe_stage_skid_if #(.DATA_W(8))  b2 ();

   logic [15:0] drop1;
   logic [1:0]  drop2;
   dbg_t        dbg1, dbg2;

   pipe_stage_skid #(.DATA_W(64), .BUBBLE_VAL(64'h0), .CNT_W(16)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .bus        (b1),
      .drop_cnt_o (drop1),
      .dbg_o      (dbg1)
   );

   pipe_stage_skid #(.DATA_W(8), .BUBBLE_VAL(8'h0), .CNT_W(2)) dut_sat (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .bus        (b2),
      .drop_cnt_o (drop2),
      .dbg_o      (dbg2)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of held entries, ready flag, stall history, drop total.
   logic [63:0] mq[$];
   logic        m_ready;
   logic        m_stall_q;
   int          m_drop;
   int          m2_drop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic occ_e exp_state(input int n);
      case (n)
         0:       return OCC_EMPTY;
         1:       return OCC_ONE;
         default: return OCC_FULL;
      endcase
   endfunction

   task automatic check_all(input string tag);
      logic [63:0] exp_data;
      exp_data = (mq.size() > 0) ? mq[0] : 64'h0;
      check({tag, ".valid"}, 64'(b1.out_valid_o), 64'(mq.size() > 0));
      check({tag, ".data"},  b1.out_data_o, exp_data);
      check({tag, ".ready"}, 64'(b1.in_ready_o), 64'(m_ready));
      check({tag, ".drop"},  64'(drop1), 64'(m_drop));
      check({tag, ".state"}, 64'(dbg1.state), 64'(exp_state(mq.size())));
      check({tag, ".stallq"}, 64'(dbg1.stall), 64'(m_stall_q));
   endtask

   task automatic step(input logic v, input logic [63:0] d, input logic ordy,
                       input logic st, input logic fl, input string tag);
      logic acc, rel;
      int   t;
      b1.in_valid_i  = v;
      b1.in_data_i   = d;
      b1.out_ready_i = ordy;
      b1.stall_i     = st;
      b1.flush_i     = fl;
      acc = v && m_ready;
      rel = (mq.size() > 0) && ordy && !st;
      @(posedge clk);
      if (fl) begin
         t = m_drop + mq.size();
         m_drop = (t > 65535) ? 65535 : t;
         mq.delete();
      end else begin
         if (rel) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
      m_ready   = (mq.size() < 2) && !st;
      m_stall_q = st;
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n          = 1'b0;
      b1.in_valid_i  = 1'b1;
      b1.in_data_i   = 64'h55;
      b1.out_ready_i = 1'b0;
      b1.stall_i     = 1'b0;
      b1.flush_i     = 1'b0;
      b2.in_valid_i  = 1'b0;
      b2.in_data_i   = 8'h0;
      b2.out_ready_i = 1'b0;
      b2.stall_i     = 1'b0;
      b2.flush_i     = 1'b0;
      m_ready   = 1'b0;
      m_stall_q = 1'b0;
      m_drop    = 0;
      m2_drop   = 0;

      // Reset held with a valid offer: nothing accepted, ready low.
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      b1.in_valid_i = 1'b0;
      rst_n = 1'b1;
      check_all("rst_release");
      step(0, 64'h0, 0, 0, 0, "ready_rise");

      // Streaming with one-cycle latency and no bubbles.
      for (int i = 1; i <= 8; i++) step(1, 64'(i), 1, 0, 0, "stream");
      step(0, 64'h0, 1, 0, 0, "stream_drain");

      // Backpressure fills the skid, then drains in order.
      step(1, 64'hA, 0, 0, 0, "bp_a");
      step(1, 64'hB, 0, 0, 0, "bp_full");
      step(0, 64'h0, 1, 0, 0, "bp_rel_a");
      step(0, 64'h0, 1, 0, 0, "bp_rel_b");

      // Stall freezes a full stage even with downstream ready.
      step(1, 64'hA, 0, 0, 0, "st_a");
      step(1, 64'hB, 0, 0, 0, "st_b");
      for (int i = 0; i < 3; i++) step(0, 64'h0, 1, 1, 0, "stall");
      step(0, 64'h0, 1, 0, 0, "st_rel_a");
      step(0, 64'h0, 1, 0, 0, "st_rel_b");

      // Flush of a full stage with a same-cycle input and stall.
      step(1, 64'hA, 0, 0, 0, "fl_a");
      step(1, 64'hB, 0, 0, 0, "fl_b");
      step(1, 64'hC, 0, 1, 1, "flush_full");
      step(0, 64'h0, 0, 0, 0, "flush_after");
      step(1, 64'hD, 0, 0, 0, "fl_d");
      step(1, 64'hE, 1, 0, 1, "flush_one_acc");
      step(0, 64'h0, 1, 0, 0, "flush_idle");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom},
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 15) == 0), "rand");
      end

      // Reset in the middle of traffic drops everything uncounted.
      step(1, 64'h11, 0, 0, 0, "mid_a");
      step(1, 64'h22, 0, 0, 0, "mid_b");
      b1.in_valid_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_ready   = 1'b0;
      m_stall_q = 1'b0;
      m_drop    = 0;
      check_all("rst_mid");
      @(posedge clk);
      #1;
      b1.in_valid_i = 1'b0;
      rst_n = 1'b1;
      step(0, 64'h0, 0, 0, 0, "after_rst");

      // Narrow counter saturates at 3 across five single-entry flushes.
      for (int k = 0; k < 5; k++) begin
         b2.in_valid_i = 1'b1;
         b2.in_data_i  = 8'(k + 1);
         @(posedge clk);
         #1;
         b2.in_valid_i = 1'b0;
         check("sat.held", 64'(b2.out_valid_o), 64'h1);
         b2.flush_i = 1'b1;
         @(posedge clk);
         #1;
         b2.flush_i = 1'b0;
         m2_drop = (m2_drop < 3) ? m2_drop + 1 : 3;
         check("sat.cnt", 64'(drop2), 64'(m2_drop));
         check("sat.empty", 64'(b2.out_valid_o), 64'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
